// File: rtl/video_chunk_requester.sv
// Issues one {vPos, chunkNum} read request per video chunk of a frame, limited by FIFO space and a pixel credit budget.
// Optional feature: define VIDEO_REQUEST_LINE_REPEAT_EN to request every line twice in succession.
module video_chunk_requester #(
    parameter int unsigned CHUNK_BITS      = 5,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned MAX_OUTSTANDING = 128
) (
    input  logic                  scalerClock,
    input  logic                  reset,
    input  logic                  frameStart,
    output logic                  requestFifoWriteEnable,
    input  logic                  requestFifoFull,
    output logic [21-CHUNK_BITS:0] requestFifoWriteData,
    input  logic                  pixelConsumed,
    output logic [11:0]           outstandingPixels,
    output logic                  busy,
    output logic                  frameDone
);

    localparam int unsigned CHUNK_SIZE = 1 << CHUNK_BITS;
    localparam int unsigned NCH        = (H_ACTIVE + CHUNK_SIZE - 1) / CHUNK_SIZE;
    localparam int unsigned V_W        = 11;
    localparam int unsigned C_W        = 11 - CHUNK_BITS;
    localparam int unsigned CNT_W      = 12;

`ifdef VIDEO_REQUEST_LINE_REPEAT_EN
    localparam bit LINE_REPEAT = 1'b1;
`else
    localparam bit LINE_REPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } stateT;

    stateT             state, stateNext;
    logic [V_W-1:0]    vPos, vPosNext;
    logic [C_W-1:0]    chunkNum, chunkNumNext;
    logic              repeatPass, repeatPassNext;
    logic [CNT_W-1:0]  outstandingNext;
    logic              frameDoneNext;
    logic              writeEnable;
    logic              creditOk;
    logic              lastChunk;
    logic              lastLine;

    // State and datapath registers
    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            vPos              <= '0;
            chunkNum          <= '0;
            repeatPass        <= 1'b0;
            outstandingPixels <= '0;
            frameDone         <= 1'b0;
        end else begin
            state             <= stateNext;
            vPos              <= vPosNext;
            chunkNum          <= chunkNumNext;
            repeatPass        <= repeatPassNext;
            outstandingPixels <= outstandingNext;
            frameDone         <= frameDoneNext;
        end
    end

    // Request qualification: one request per cycle while credit and FIFO space allow
    always_comb begin
        creditOk    = ((CNT_W + 1)'(outstandingPixels) + (CNT_W + 1)'(CHUNK_SIZE))
                      <= (CNT_W + 1)'(MAX_OUTSTANDING);
        writeEnable = (state == ISSUE) && !requestFifoFull && creditOk;
        lastChunk   = (chunkNum == C_W'(NCH - 1));
        lastLine    = (vPos == V_W'(V_ACTIVE - 1));
    end

    // Next-state and position sequencing
    always_comb begin
        stateNext      = state;
        vPosNext       = vPos;
        chunkNumNext   = chunkNum;
        repeatPassNext = repeatPass;
        frameDoneNext  = 1'b0;

        case (state)
            IDLE: begin
                if (frameStart) begin
                    stateNext      = ISSUE;
                    vPosNext       = '0;
                    chunkNumNext   = '0;
                    repeatPassNext = 1'b0;
                end
            end
            ISSUE: begin
                if (writeEnable) begin
                    if (!lastChunk) begin
                        chunkNumNext = chunkNum + C_W'(1);
                    end else begin
                        chunkNumNext = '0;
                        if (LINE_REPEAT && !repeatPass) begin
                            repeatPassNext = 1'b1;
                        end else begin
                            repeatPassNext = 1'b0;
                            if (lastLine) begin
                                vPosNext  = '0;
                                stateNext = DRAIN;
                            end else begin
                                vPosNext = vPos + V_W'(1);
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (outstandingPixels == '0) begin
                    stateNext     = IDLE;
                    frameDoneNext = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Credit counter: +CHUNK_SIZE per request, -1 per consumed pixel, floor at zero
    always_comb begin
        outstandingNext = outstandingPixels;
        case ({writeEnable, pixelConsumed})
            2'b10:   outstandingNext = outstandingPixels + CNT_W'(CHUNK_SIZE);
            2'b11:   outstandingNext = outstandingPixels + CNT_W'(CHUNK_SIZE - 1);
            2'b01:   outstandingNext = (outstandingPixels == '0) ? '0
                                       : outstandingPixels - CNT_W'(1);
            default: outstandingNext = outstandingPixels;
        endcase
    end

    assign requestFifoWriteEnable = writeEnable;
    assign requestFifoWriteData   = {vPos, chunkNum};
    assign busy                   = (state != IDLE);

endmodule

// File: tb/tb_video_chunk_requester.sv
// Bench for video_chunk_requester: table-driven start-of-frame vectors, directed corner sequences and randomized traffic
// against a request-list / credit reference model, on two instances (credit budget 128 and 32).
module tb_video_chunk_requester;

    localparam int unsigned H   = 64;
    localparam int unsigned V   = 2;
    localparam int unsigned CB  = 5;
    localparam int unsigned CS  = 32;
    localparam int unsigned NCH = (H + CS - 1) / CS;
`ifdef VIDEO_REQUEST_LINE_REPEAT_EN
    localparam int unsigned REPS = 2;
`else
    localparam int unsigned REPS = 1;
`endif
    localparam int TOTAL = int'(V * NCH * REPS);

    logic        clk;
    logic        reset;
    logic        frameStart;
    logic        full;
    logic        consumed;
    logic [1:0]  we;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [16:0] wd [2];
    logic [11:0] op [2];

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: ordered list of expected requests plus a pixel credit count per instance
    int expSeq[$];
    bit mActive [2];
    int mIdx    [2];
    int mOut    [2];
    bit mDone   [2];
    int maxOut  [2] = '{128, 32};
    int nWr     [2];
    int nDoneP  [2];

    typedef struct {
        bit fs;
        bit fl;
        bit cs;
        bit eWe;
        bit eBusy;
        int eData;
        int eOut;
    } vecT;

    vecT tbl [5];

    video_chunk_requester #(
        .CHUNK_BITS(CB), .H_ACTIVE(H), .V_ACTIVE(V), .MAX_OUTSTANDING(128)
    ) dut0 (
        .scalerClock(clk), .reset(reset), .frameStart(frameStart),
        .requestFifoWriteEnable(we[0]), .requestFifoFull(full),
        .requestFifoWriteData(wd[0]), .pixelConsumed(consumed),
        .outstandingPixels(op[0]), .busy(busy[0]), .frameDone(done[0])
    );

    video_chunk_requester #(
        .CHUNK_BITS(CB), .H_ACTIVE(H), .V_ACTIVE(V), .MAX_OUTSTANDING(32)
    ) dut1 (
        .scalerClock(clk), .reset(reset), .frameStart(frameStart),
        .requestFifoWriteEnable(we[1]), .requestFifoFull(full),
        .requestFifoWriteData(wd[1]), .pixelConsumed(consumed),
        .outstandingPixels(op[1]), .busy(busy[1]), .frameDone(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s (dut%0d) at %0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mActive[k] = 1'b0;
            mIdx[k]    = 0;
            mOut[k]    = 0;
            mDone[k]   = 1'b0;
            nWr[k]     = 0;
            nDoneP[k]  = 0;
        end
    endtask

    task automatic checkAllZero(input string name);
        for (int k = 0; k < 2; k++) begin
            check({name, ".writeEnable"}, k, int'(we[k]), 0);
            check({name, ".writeData"},   k, int'(wd[k]), 0);
            check({name, ".outstanding"}, k, int'(op[k]), 0);
            check({name, ".busy"},        k, int'(busy[k]), 0);
            check({name, ".frameDone"},   k, int'(done[k]), 0);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1; frameStart = 1'b0; full = 1'b0; consumed = 1'b0;
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // One clock: drive inputs, compare both instances with the model, then advance the model over the edge
    task automatic cycle(input bit fs, input bit fl, input bit cs);
        @(negedge clk);
        frameStart = fs; full = fl; consumed = cs;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit issuing;
            bit eWe;
            bit wasIdle;
            issuing = mActive[k] && (mIdx[k] < TOTAL);
            eWe     = issuing && !fl && (mOut[k] + int'(CS) <= maxOut[k]);
            wasIdle = !mActive[k];
            check("writeEnable", k, int'(we[k]), int'(eWe));
            check("busy",        k, int'(busy[k]), int'(mActive[k]));
            check("frameDone",   k, int'(done[k]), int'(mDone[k]));
            check("outstanding", k, int'(op[k]), mOut[k]);
            if (issuing) check("writeData", k, int'(wd[k]), expSeq[mIdx[k]]);
            if (we[k])   nWr[k]++;
            if (done[k]) nDoneP[k]++;
            mDone[k] = mActive[k] && (mIdx[k] == TOTAL) && (mOut[k] == 0);
            if (mDone[k]) mActive[k] = 1'b0;
            if (eWe) begin
                mOut[k] += int'(CS);
                mIdx[k]++;
            end
            if (cs && mOut[k] > 0) mOut[k]--;
            if (wasIdle && fs) begin
                mActive[k] = 1'b1;
                mIdx[k]    = 0;
            end
        end
    endtask

    task automatic runToIdle(input int limit);
        int n;
        n = 0;
        while (busy != 2'b00 && n < limit) begin
            cycle(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("drainBound", 0, int'(busy), 0);
    endtask

    initial begin
        bit doneSeen;
        int wr;

        reset = 1'b1; frameStart = 1'b0; full = 1'b0; consumed = 1'b0;
        for (int v = 0; v < int'(V); v++)
            for (int r = 0; r < int'(REPS); r++)
                for (int c = 0; c < int'(NCH); c++)
                    expSeq.push_back((v << (11 - CB)) | c);

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,         0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, expSeq[0], 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, expSeq[1], 31};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, expSeq[2], 62};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, expSeq[3], 93};

        applyReset();

        // Start of frame with a consume every cycle: back-to-back requests, net +31 credit each
        wr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            frameStart = tbl[i].fs; full = tbl[i].fl; consumed = tbl[i].cs;
            #1;
            check("tbl.writeEnable", 0, int'(we[0]), int'(tbl[i].eWe));
            check("tbl.busy",        0, int'(busy[0]), int'(tbl[i].eBusy));
            check("tbl.outstanding", 0, int'(op[0]), tbl[i].eOut);
            check("tbl.writeData",   0, int'(wd[0]), tbl[i].eData);
            if (we[0]) wr++;
        end
        doneSeen = 1'b0;
        for (int i = 0; i < 600 && !doneSeen; i++) begin
            @(negedge clk);
            frameStart = 1'b0; full = 1'b0; consumed = 1'b1;
            #1;
            if (we[0])   wr++;
            if (done[0]) doneSeen = 1'b1;
        end
        check("frameDoneSeen", 0, int'(doneSeen), 1);
        check("frameWrites",   0, wr, TOTAL);
        check("busyAtDone",    0, int'(busy[0]), 0);
        @(negedge clk);
        consumed = 1'b0;
        #1;
        check("donePulseWidth", 0, int'(done[0]), 0);

        // No consumption: credit caps requests, drain holds until every pixel is consumed
        applyReset();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
        check("creditCapWrites", 0, nWr[0], 4);
        check("creditCapOut",    0, int'(op[0]), 128);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 1'b1);
        check("drainHoldsBusy",  0, int'(busy[0]), 1);
        runToIdle(2000);
        cycle(1'b0, 1'b0, 1'b0);
        check("drainDonePulses", 0, nDoneP[0], 1);
        check("drainDonePulses", 1, nDoneP[1], 1);
        check("drainWrites",     1, nWr[1], TOTAL);

        // FIFO full for five cycles mid-frame
        applyReset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        runToIdle(2000);
        check("fullWrites", 0, nWr[0], TOTAL);

        // Asynchronous reset after the second request, then stray consumes and a clean restart
        applyReset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        frameStart = 1'b0; full = 1'b0; consumed = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("asyncReset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        runToIdle(2000);

        // Randomized traffic with frameStart pulses arriving at any time
        applyReset();
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end
        runToIdle(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
